// File: rtl/vga_image_viewer_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the image-viewer PIO: word address, select,
// active-low write strobe and 32-bit data in both directions.
interface vga_image_viewer_pio_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/vga_image_viewer_pio_ctrl.sv
// Avalon-MM PIO: output register with set/clear, synchronised input with edge
// capture and masked level irq. Define PIO_TOGGLE_EN to map OUTTOG at address 6.
module vga_image_viewer_pio_ctrl #(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter int                EDGE_MODE   = 0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  vga_image_viewer_pio_ctrl_if.slave   bus,
  input  logic [DATA_W-1:0]            in_port,
  output logic [DATA_W-1:0]            out_port,
  output logic                         irq
);

`ifdef PIO_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic [DATA_W-1:0] out_q, out_d, mask_q, mask_d, edge_q, edge_d, prev_q, prev_d;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0] vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0] wd, clr, raw, det, sync_last;
  logic              wr;
  logic [31:0]       rd;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    wd         = bus.writedata[DATA_W-1:0];
    wr         = bus.chipselect & ~bus.write_n;
    sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d     = sync_last;
    // Tracks which stages hold post-reset samples; edges are only trusted once
    // the delayed copy is real, so a chain refilling after reset is not an edge.
    vld_pipe_d = {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
    case (EDGE_MODE)
      1:       raw = ~sync_last & prev_q;
      2:       raw = sync_last ^ prev_q;
      default: raw = sync_last & ~prev_q;
    endcase
    det    = vld_pipe_q[SYNC_STAGES] ? raw : '0;
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr) begin
      case (bus.address)
        3'd0: out_d  = wd;
        3'd2: mask_d = wd;
        3'd3: clr    = wd;
        3'd4: out_d  = out_q | wd;
        3'd5: out_d  = out_q & ~wd;
        3'd6: if (TOG_EN) out_d = out_q ^ wd;
        default: ;
      endcase
    end
    // New edge dominates a same-cycle W1C.
    edge_d = (edge_q & ~clr) | det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= RESET_VAL;
      mask_q     <= '0;
      edge_q     <= '0;
      prev_q     <= '0;
      sync_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      out_q      <= out_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      prev_q     <= prev_d;
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address)
      3'd0: rd[DATA_W-1:0] = out_q;
      3'd1: rd[DATA_W-1:0] = sync_last;
      3'd2: rd[DATA_W-1:0] = mask_q;
      3'd3: rd[DATA_W-1:0] = edge_q;
      default: ;
    endcase
  end

  assign bus.readdata = rd;
  assign out_port     = out_q;
  assign irq          = |(edge_q & mask_q);

endmodule
